// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage issue/hazard controller for the HI/LO multiply/divide unit
// Optional busy cross-check against the unit's Busy is enabled by defining MD_CHECK_EN.
module md_issue_ctrl #(
    parameter int MULT_CYC = 4,
    parameter int DIV_CYC  = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_e,
    input  logic        ex_flush,
    input  logic        md_busy,
    output logic [31:0] instr_md_e,
    output logic [2:0]  md_op_e,
    output logic        md_start_e,
    output logic        stall_d,
    output logic        md_busy_q,
    output logic        md_err
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;

    logic       special_e, special_d;
    logic [2:0] op_raw_e;
    logic       is_mul_e, is_div_e;
    logic       md_class_d;

    assign special_e = (instr_e[31:26] == 6'b000000);
    assign special_d = (instr_d[31:26] == 6'b000000);

    always_comb begin
        op_raw_e = 3'b000;
        is_mul_e = 1'b0;
        is_div_e = 1'b0;
        if (special_e) begin
            case (instr_e[5:0])
                F_MULT:  begin op_raw_e = 3'b001; is_mul_e = 1'b1; end
                F_MULTU: begin op_raw_e = 3'b010; is_mul_e = 1'b1; end
                F_DIV:   begin op_raw_e = 3'b011; is_div_e = 1'b1; end
                F_DIVU:  begin op_raw_e = 3'b100; is_div_e = 1'b1; end
                F_MTLO:  op_raw_e = 3'b101;
                F_MTHI:  op_raw_e = 3'b110;
                default: op_raw_e = 3'b000;
            endcase
        end
    end

    // mfhi/mflo carry no op code but still read HI/LO, so they count for the D-stage hazard.
    always_comb begin
        md_class_d = 1'b0;
        if (special_d) begin
            case (instr_d[5:0])
                F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                F_MULT, F_MULTU, F_DIV, F_DIVU: md_class_d = 1'b1;
                default:                        md_class_d = 1'b0;
            endcase
        end
    end

    assign instr_md_e = ex_flush ? 32'h0 : instr_e;
    assign md_op_e    = ex_flush ? 3'b000 : op_raw_e;
    assign md_start_e = ~ex_flush & (is_mul_e | is_div_e);

    assign md_busy_q  = (state != IDLE);
    assign stall_d    = md_class_d & (md_start_e | md_busy_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A start seen while already busy is ignored: only IDLE looks at md_start_e.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (md_start_e) begin
                    if (is_mul_e) begin
                        state_nx = MULT;
                        cnt_nx   = MULT_CNT;
                    end else begin
                        state_nx = DIV;
                        cnt_nx   = DIV_CNT;
                    end
                end
            end
            MULT, DIV: begin
                if (cnt <= 4'd1) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx   = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    logic [19:0] unused_instr_d;
    assign unused_instr_d = instr_d[25:6];

`ifdef MD_CHECK_EN
    logic err_q;

    // Sticky: a single-cycle disagreement is enough to flag a hung or early-finishing unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (md_busy != md_busy_q) begin
            err_q <= 1'b1;
        end
    end

    assign md_err = err_q;
`else
    logic unused_md_busy;
    assign unused_md_busy = md_busy;
    assign md_err         = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - self-checking bench for md_issue_ctrl with a cycle-stamp reference model
module tb_md_issue_ctrl;

    localparam int MULT_CYC = 4;
    localparam int DIV_CYC  = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_d, instr_e;
    logic        ex_flush, md_busy;
    logic [31:0] instr_md_e;
    logic [2:0]  md_op_e;
    logic        md_start_e, stall_d, md_busy_q, md_err;

    md_issue_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
        .ex_flush(ex_flush), .md_busy(md_busy), .instr_md_e(instr_md_e),
        .md_op_e(md_op_e), .md_start_e(md_start_e), .stall_d(stall_d),
        .md_busy_q(md_busy_q), .md_err(md_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_end = -1;

    logic [5:0] md_f [8] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h11, 6'h12, 6'h13};

    function automatic logic [31:0] sp(input logic [5:0] f);
        return {6'b000000, 20'($urandom), f};
    endfunction

    function automatic int ref_op(input logic [31:0] w);
        if (w[31:26] != 6'b0) return 0;
        case (w[5:0])
            6'h18: return 1;
            6'h19: return 2;
            6'h1a: return 3;
            6'h1b: return 4;
            6'h13: return 5;
            6'h11: return 6;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_class(input logic [31:0] w);
        return (w[31:26] == 6'b0) && (w[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, [6'h18:6'h1b]});
    endfunction

    function automatic logic [5:0] exp_vec();
        int op;
        bit st, bz;
        op = ex_flush ? 0 : ref_op(instr_e);
        st = (op >= 1) && (op <= 4);
        bz = (cyc <= busy_end);
        return {3'(op), st, ref_class(instr_d) && (st || bz), bz};
    endfunction

    // Model: an accepted issue at cycle c makes the mirror busy for cycles c+1 .. c+N.
    task automatic tick();
        int op, n;
        bit iss;
        op  = ref_op(instr_e);
        iss = !reset && !ex_flush && (op >= 1) && (op <= 4) && !(cyc <= busy_end);
        n   = (op <= 2) ? MULT_CYC : DIV_CYC;
        @(posedge clk);
        if (reset) busy_end = -1;
        else if (iss) busy_end = cyc + n;
        cyc++;
        #1;
        md_busy = (cyc <= busy_end);
    endtask

    task automatic test_reset();
        reset = 1; instr_d = 0; instr_e = 0; ex_flush = 0; md_busy = 0;
        tick(); tick();
        n_cmp++;
        if ({md_op_e, md_start_e, stall_d, md_busy_q, md_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=0000000", {md_op_e, md_start_e, stall_d, md_busy_q, md_err});
        end
        reset = 0; tick();
        n_cmp++;
        if ({md_busy_q, stall_d, instr_md_e} !== 34'h0) begin
            n_bad++;
            $display("FAIL post_reset got busy=%b stall=%b ins=%h want 0", md_busy_q, stall_d, instr_md_e);
        end
    endtask

    task automatic test_mult_stall();
        instr_e = sp(6'h18); instr_d = sp(6'h12); #1;
        n_cmp++;
        if (md_op_e !== 3'b001 || stall_d !== 1'b1 || md_start_e !== 1'b1) begin
            n_bad++;
            $display("FAIL mult_issue got op=%b stall=%b start=%b want 001/1/1", md_op_e, stall_d, md_start_e);
        end
        tick(); instr_e = 0; #1;
        for (int i = 1; i <= MULT_CYC; i++) begin
            n_cmp++;
            if (md_busy_q !== 1'b1 || stall_d !== 1'b1) begin
                n_bad++;
                $display("FAIL mult_window c%0d got busy=%b stall=%b want 1/1", i, md_busy_q, stall_d);
            end
            tick();
        end
        n_cmp++;
        if (md_busy_q !== 1'b0 || stall_d !== 1'b0) begin
            n_bad++;
            $display("FAIL mult_release got busy=%b stall=%b want 0/0", md_busy_q, stall_d);
        end
    endtask

    task automatic test_divu_window();
        int cnt = 0;
        instr_e = sp(6'h1b); instr_d = 32'h0109_5020; #1;
        n_cmp++;
        if (md_op_e !== 3'b100 || stall_d !== 1'b0) begin
            n_bad++;
            $display("FAIL divu_issue got op=%b stall=%b want 100/0", md_op_e, stall_d);
        end
        tick(); instr_e = 0;
        while (md_busy_q === 1'b1 && cnt < 20) begin
            cnt++;
            if (cnt == 3) instr_d = sp(6'h11);
            #1;
            n_cmp++;
            if (stall_d !== (cnt >= 3)) begin
                n_bad++;
                $display("FAIL divu_mthi_stall c%0d got=%b want=%b", cnt, stall_d, cnt >= 3);
            end
            tick();
        end
        n_cmp++;
        if (cnt != DIV_CYC || stall_d !== 1'b0) begin
            n_bad++;
            $display("FAIL divu_busy_len got=%0d stall=%b want=%0d stall=0", cnt, stall_d, DIV_CYC);
        end
    endtask

    task automatic test_flush_issue();
        instr_e = sp(6'h1a); instr_d = sp(6'h10); ex_flush = 1; #1;
        n_cmp++;
        if (instr_md_e !== 32'h0 || md_op_e !== 3'b000 || md_start_e !== 1'b0 || stall_d !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_issue got ins=%h op=%b start=%b stall=%b want 0", instr_md_e, md_op_e, md_start_e, stall_d);
        end
        tick(); ex_flush = 0; instr_e = 0; #1;
        n_cmp++;
        if (md_busy_q !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_idle got busy=%b want 0", md_busy_q);
        end
    endtask

    task automatic test_flush_inflight();
        int cnt = 0;
        instr_e = sp(6'h19); instr_d = 0; #1;
        n_cmp++;
        if (md_op_e !== 3'b010 || instr_md_e !== instr_e) begin
            n_bad++;
            $display("FAIL multu_issue got op=%b ins=%h want 010/%h", md_op_e, instr_md_e, instr_e);
        end
        tick(); instr_e = 0;
        while (md_busy_q === 1'b1 && cnt < 20) begin
            cnt++;
            ex_flush = (cnt == 2);
            tick();
        end
        ex_flush = 0;
        n_cmp++;
        if (cnt != MULT_CYC) begin
            n_bad++;
            $display("FAIL flush_inflight_len got=%0d want=%0d", cnt, MULT_CYC);
        end
    endtask

    task automatic test_reset_mid();
        instr_e = sp(6'h1a); tick(); instr_e = 0; tick(); tick();
        reset = 1; tick(); reset = 0; #1;
        n_cmp++;
        if (md_busy_q !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid got busy=%b want 0", md_busy_q);
        end
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 11);
            case (r)
                8:  instr_e = {6'($urandom_range(1, 63)), 20'($urandom), md_f[$urandom_range(0, 7)]};
                9:  instr_e = sp(6'h20);
                10: instr_e = 32'h0;
                11: instr_e = $urandom;
                default: instr_e = sp(md_f[r]);
            endcase
            instr_d  = ($urandom_range(0, 2) == 0) ? $urandom : sp(md_f[$urandom_range(0, 7)]);
            ex_flush = ($urandom_range(0, 4) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            #1;
            n_cmp++;
            if ({md_op_e, md_start_e, stall_d, md_busy_q} !== exp_vec()
                || instr_md_e !== (ex_flush ? 32'h0 : instr_e) || md_err !== 1'b0) begin
                n_bad++;
                $display("FAIL random k%0d got op/st/stall/busy=%b ins=%h err=%b want %b ins=%h err=0",
                         k, {md_op_e, md_start_e, stall_d, md_busy_q}, instr_md_e, md_err, exp_vec(),
                         ex_flush ? 32'h0 : instr_e);
            end
            tick();
        end
        reset = 0; ex_flush = 0; instr_e = 0; instr_d = 0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_check();
`ifdef MD_CHECK_EN
        instr_e = sp(6'h18); tick(); instr_e = 0;
        for (int i = 0; i < MULT_CYC; i++) tick();
        md_busy = 1'b1; #1;
        n_cmp++;
        if (md_err !== 1'b0) begin
            n_bad++;
            $display("FAIL check_pre got err=%b want 0", md_err);
        end
        tick(); tick(); tick();
        n_cmp++;
        if (md_err !== 1'b1) begin
            n_bad++;
            $display("FAIL check_sticky got err=%b want 1", md_err);
        end
        reset = 1; tick(); reset = 0; #1;
        n_cmp++;
        if (md_err !== 1'b0) begin
            n_bad++;
            $display("FAIL check_reset got err=%b want 0", md_err);
        end
`else
        md_busy = 1'b1; tick(); md_busy = 1'b1; tick(); #1;
        n_cmp++;
        if (md_err !== 1'b0) begin
            n_bad++;
            $display("FAIL check_disabled got err=%b want 0", md_err);
        end
        md_busy = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_mult_stall();
        test_divu_window();
        test_flush_issue();
        test_flush_inflight();
        test_reset_mid();
        test_random();
        test_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
